// File: rtl/char_mem_arbiter.sv
// char_mem_arbiter: shares one single-port character RAM between a CPU
// (read/write) and a VGA scan-out reader (read-only). VGA wins contention by
// default; a CPU that has waited MAX_WAIT cycles overrides it. Grants are
// combinational single-beat accesses; a small owner FSM routes the 1-cycle
// RAM read latency back to whichever requester issued the read.
module char_mem_arbiter #(
  parameter int AW       = 8,
  parameter int DW       = 8,
  parameter int MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          reset,
  // CPU side
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  // VGA side
  input  logic          vga_req,
  input  logic [AW-1:0] vga_addr,
  output logic          vga_gnt,
  output logic          vga_rvalid,
  output logic [DW-1:0] vga_rdata,
  // RAM side
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int WW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0] WAIT_SAT = WW'(MAX_WAIT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CPU_RD = 2'd1,
    VGA_RD = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [WW-1:0] wait_q, wait_d;
  logic          cpu_rvalid_q, vga_rvalid_q;
  logic          cpu_gnt_w, vga_gnt_w;
  logic          cpu_starved;

  // The CPU has waited long enough to take the RAM even against VGA.
  assign cpu_starved = (wait_q == WAIT_SAT);

  // Grant decision: reset blocks everything, otherwise VGA priority unless
  // the CPU is alone or starved.
  always_comb begin
    cpu_gnt_w = 1'b0;
    vga_gnt_w = 1'b0;
    if (!reset) begin
      if (cpu_req && (!vga_req || cpu_starved)) begin
        cpu_gnt_w = 1'b1;
      end else if (vga_req) begin
        vga_gnt_w = 1'b1;
      end
    end
  end

  assign cpu_gnt = cpu_gnt_w;
  assign vga_gnt = vga_gnt_w;

  // RAM port mux: the granted requester drives the RAM, idle drives zeros.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (cpu_gnt_w) begin
      mem_en    = 1'b1;
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (vga_gnt_w) begin
      mem_en    = 1'b1;
      mem_addr  = vga_addr;
    end
  end

  // CPU wait counter: counts denied request cycles, saturates, and clears
  // whenever the CPU is served or stops asking.
  always_comb begin
    wait_d = wait_q;
    if (!cpu_req || cpu_gnt_w) begin
      wait_d = '0;
    end else if (wait_q != WAIT_SAT) begin
      wait_d = wait_q + WW'(1);
    end
  end

  // Next read owner depends only on this cycle's grant, so back-to-back
  // reads pipeline cleanly; a CPU write leaves nothing in flight.
  always_comb begin
    state_d = IDLE;
    if (cpu_gnt_w && !cpu_we) begin
      state_d = CPU_RD;
    end else if (vga_gnt_w) begin
      state_d = VGA_RD;
    end
  end

  // Owner FSM and counter registers; rvalid flags are registered alongside
  // the state so they are glitch-free and exactly track it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      wait_q       <= '0;
      cpu_rvalid_q <= 1'b0;
      vga_rvalid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_q       <= wait_d;
      cpu_rvalid_q <= (state_d == CPU_RD);
      vga_rvalid_q <= (state_d == VGA_RD);
    end
  end

  assign cpu_rvalid = cpu_rvalid_q;
  assign vga_rvalid = vga_rvalid_q;

  // Read data is shared; the rvalid flags say whose it is.
  assign cpu_rdata = mem_rdata;
  assign vga_rdata = mem_rdata;

endmodule
